serial_full_adder: RTL and testbench
====================================

# serial_full_adder

Bit-serial adder that adds two WIDTH-bit operands LSB-first, one bit per clock. A single 1-bit full-adder cell and a carry flip-flop do the arithmetic. It is the additive counterpart to the team's gate-level 1-bit full subtractor and the building block for the serial add/subtract datapath. A start/busy/done handshake brackets each operation, and both a serial bit stream and a parallel result are provided.

## Interface
- WIDTH, 8, operand and result width in bits; legal range WIDTH >= 1
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- a  input  WIDTH  augend, captured on accepted start
- b  input  WIDTH  addend, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- busy  output  1  high while bits are being processed (RUN)
- done  output  1  one-cycle completion pulse (DONE)
- sum  output  WIDTH  parallel result, held until the next completion
- cout  output  1  final carry, held with sum
- ser_sum  output  1  current serial sum bit, LSB first
- ser_valid  output  1  ser_sum qualifier; equals busy

## Operation
- State machine has three states: IDLE, RUN and DONE.
  - IDLE -> RUN on start.
  - RUN -> DONE after WIDTH RUN cycles.
  - DONE -> RUN if start is high, otherwise DONE -> IDLE.
- Accepted start (IDLE or DONE with start=1) loads the following registers:
  - shift_a <= a, shift_b <= b, carry <= cin, bit count <= 0.
- Each RUN cycle, combinationally:
  - s = shift_a[0] ^ shift_b[0] ^ carry
  - c = majority(shift_a[0], shift_b[0], carry)
- At the edge ending each RUN cycle:
  - carry <= c.
  - The accumulator shifts right with s entering at bit WIDTH-1.
  - shift_a and shift_b shift right.
  - The count increments.
- ser_sum = s while in RUN; ser_sum = 0 otherwise.
- Completion: at the edge ending the RUN cycle with count == WIDTH-1, the block loads sum <= final accumulator contents (including that cycle's s) and cout <= c, and the state goes to DONE.
- sum and cout change only at completion and at reset. They are never disturbed during a later run.
- start during RUN is ignored and has no effect on the operation in progress.
- The arithmetic is unsigned modulo 2^WIDTH; the overflow bit goes to cout, giving {cout,sum} = a + b + cin exactly.
- Reset (synchronous, any state, including mid-RUN):
  - state -> IDLE.
  - busy, done, ser_sum, ser_valid, sum, cout -> 0.
  - Internal shift registers, carry and count -> 0.
  - Any partial result is discarded.
  - rst has priority over start in the same cycle.

## Timing
- Cycle numbering: start is sampled high at edge E0.
- busy and ser_valid are high for cycles E0..E(WIDTH-1), i.e. exactly WIDTH cycles; bit i of the result appears on ser_sum in cycle i.
- done is high for the single cycle following edge E(WIDTH); sum and cout are valid from that same cycle.
- Latency from start to done is WIDTH+1 edges; there is no combinational path from start to any output.
- Back-to-back operation:
  - start held or pulsed during the DONE cycle begins the next run immediately.
  - In that case done is high for exactly one cycle and busy returns high in the next cycle.
  - Throughput is one result per WIDTH+1 cycles.
- With WIDTH=1: one RUN cycle, then DONE.

## Test plan
- Reset then idle: hold rst 2 cycles, start=0 for 5 cycles -> every output 0, busy never high.
- 8-bit add: a=0x35, b=0x4A, cin=0 -> busy high exactly 8 cycles; ser_sum sequence LSB-first 1,1,1,1,1,1,1,0; done one cycle; sum=0x7F, cout=0.
- Carry chain: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- start ignored while busy:
  - Start a=0x10, b=0x20.
  - Pulse start with a=0xAA, b=0x55 in RUN cycle 3.
  - Required: result sum=0x30, cout=0; done pulses once; no second run follows.
- Back-to-back from DONE:
  - Hold start high continuously with a=0x01, b=0x01 and then a=0x80, b=0x80.
  - Required: done pulses every 9 cycles; sum is 0x02 then 0x00 with cout=1.
  - sum is held unchanged through the second run until its completion.
- Reset mid-run:
  - Assert rst in RUN cycle 4 of a=0xF0, b=0x0F.
  - Required: next cycle busy=0, sum=0, cout=0, done never pulses.
  - A fresh start afterwards with a=0x03, b=0x04 gives sum=0x07.

Source files
------------

// File: rtl/serial_full_adder.sv
// rtl/serial_full_adder.sv - bit-serial LSB-first adder with start/busy/done handshake
module serial_full_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ser_sum,
  output logic             ser_valid
);

  // Counter must be at least one bit wide so WIDTH=1 still elaborates.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_a;
  logic [WIDTH-1:0] shift_b;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CW-1:0]    count;

  logic             s;
  logic             c;
  logic [WIDTH:0]   acc_ext;
  logic [WIDTH-1:0] acc_next;

  // One full-adder cell on the operand LSBs plus the next accumulator value.
  // The accumulator shift goes through a WIDTH+1 wide temporary so WIDTH=1
  // needs no special slicing.
  always_comb begin
    s        = shift_a[0] ^ shift_b[0] ^ carry;
    c        = (shift_a[0] & shift_b[0]) | (shift_a[0] & carry) | (shift_b[0] & carry);
    acc_ext  = {s, acc};
    acc_next = acc_ext[WIDTH:1];
  end

  // Serial bit is only meaningful while processing; forced low elsewhere.
  always_comb begin
    ser_sum = (state == RUN) ? s : 1'b0;
  end

  // Control FSM and datapath registers; all handshake outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      ser_valid <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      shift_a   <= '0;
      shift_b   <= '0;
      acc       <= '0;
      carry     <= 1'b0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            shift_a   <= a;
            shift_b   <= b;
            carry     <= cin;
            count     <= '0;
            state     <= RUN;
            busy      <= 1'b1;
            ser_valid <= 1'b1;
          end
        end

        RUN: begin
          // start is deliberately not looked at here.
          carry   <= c;
          acc     <= acc_next;
          shift_a <= shift_a >> 1;
          shift_b <= shift_b >> 1;
          count   <= count + CW'(1);
          if (count == LAST) begin
            sum       <= acc_next;
            cout      <= c;
            state     <= DONE;
            busy      <= 1'b0;
            ser_valid <= 1'b0;
            done      <= 1'b1;
          end
        end

        DONE: begin
          done <= 1'b0;
          if (start) begin
            shift_a   <= a;
            shift_b   <= b;
            carry     <= cin;
            count     <= '0;
            state     <= RUN;
            busy      <= 1'b1;
            ser_valid <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          ser_valid <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_full_adder.sv
// tb/tb_serial_full_adder.sv - directed table-driven bench for serial_full_adder
module tb_serial_full_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ser_sum;
  logic         ser_valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vcin;
    logic [W-1:0] esum;
    logic         ecout;
  } vec_t;

  vec_t vecs[9];

  serial_full_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .ser_sum  (ser_sum),
    .ser_valid(ser_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change on the falling edge, outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vcin,
                        input logic [W-1:0] esum, input logic ecout, input string name);
    start = 1'b1; a = va; b = vb; cin = vcin;
    tick();
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      chk({name, " busy"}, 32'(busy), 32'd1);
      chk({name, " ser_valid"}, 32'(ser_valid), 32'd1);
      chk({name, " ser_sum"}, 32'(ser_sum), 32'(esum[i]));
      chk({name, " done_low"}, 32'(done), 32'd0);
      tick();
    end
    chk({name, " done"}, 32'(done), 32'd1);
    chk({name, " busy_low"}, 32'(busy), 32'd0);
    chk({name, " sum"}, 32'(sum), 32'(esum));
    chk({name, " cout"}, 32'(cout), 32'(ecout));
    tick();
    chk({name, " done_once"}, 32'(done), 32'd0);
    chk({name, " idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
    vecs[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    vecs[8] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;

    // reset held two cycles, then idle for five
    for (int i = 0; i < 7; i++) begin
      if (i == 2) rst = 1'b0;
      tick();
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst sum", 32'(sum), 32'd0);
      chk("rst cout", 32'(cout), 32'd0);
      chk("rst ser_sum", 32'(ser_sum), 32'd0);
      chk("rst ser_valid", 32'(ser_valid), 32'd0);
    end

    // table-driven vectors
    for (int k = 0; k < 9; k++)
      run_op(vecs[k].va, vecs[k].vb, vecs[k].vcin, vecs[k].esum, vecs[k].ecout, $sformatf("vec%0d", k));

    // start pulsed in RUN cycle 3 must be ignored
    start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i == 3) begin start = 1'b1; a = 8'hAA; b = 8'h55; end
      else start = 1'b0;
      chk("ign busy", 32'(busy), 32'd1);
      chk("ign ser_sum", 32'(ser_sum), 32'((8'h30 >> i) & 8'h01));
      tick();
    end
    start = 1'b0;
    chk("ign done", 32'(done), 32'd1);
    chk("ign sum", 32'(sum), 32'h30);
    chk("ign cout", 32'(cout), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ign no_rerun busy", 32'(busy), 32'd0);
      chk("ign no_rerun done", 32'(done), 32'd0);
    end

    // back-to-back with start held high
    start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b0;
    tick();
    for (int i = 0; i < W; i++) begin
      chk("b2b1 busy", 32'(busy), 32'd1);
      chk("b2b1 done_low", 32'(done), 32'd0);
      tick();
    end
    chk("b2b1 done", 32'(done), 32'd1);
    chk("b2b1 sum", 32'(sum), 32'h02);
    chk("b2b1 cout", 32'(cout), 32'd0);
    a = 8'h80; b = 8'h80;
    tick();
    for (int i = 0; i < W; i++) begin
      chk("b2b2 busy", 32'(busy), 32'd1);
      chk("b2b2 done_low", 32'(done), 32'd0);
      chk("b2b2 sum_held", 32'(sum), 32'h02);
      chk("b2b2 cout_held", 32'(cout), 32'd0);
      if (i == W - 1) start = 1'b0;
      tick();
    end
    chk("b2b2 done", 32'(done), 32'd1);
    chk("b2b2 sum", 32'(sum), 32'h00);
    chk("b2b2 cout", 32'(cout), 32'd1);
    tick();
    chk("b2b2 done_once", 32'(done), 32'd0);
    chk("b2b2 idle", 32'(busy), 32'd0);

    // reset in RUN cycle 4
    start = 1'b1; a = 8'hF0; b = 8'h0F; cin = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("mid busy", 32'(busy), 32'd1);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid rst busy", 32'(busy), 32'd0);
    chk("mid rst sum", 32'(sum), 32'd0);
    chk("mid rst cout", 32'(cout), 32'd0);
    chk("mid rst ser_valid", 32'(ser_valid), 32'd0);
    for (int i = 0; i < 10; i++) begin
      chk("mid no_done", 32'(done), 32'd0);
      tick();
    end
    run_op(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
